coax_rx_ctrl: RTL and testbench

Receive-side controller that sequences `coax_rx` for one response frame at a time. After a transmit the host arms it. It waits, with an optional timeout, for the receiver to go active, then drains every received 10-bit word into an internal FIFO. At frame end it reports length and status. It sits between `coax_rx` and the host/interface logic.

---
 rtl/coax_pkg.sv | 15 +
 rtl/coax_sync_fifo.sv | 50 +++++
 rtl/coax_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_coax_rx_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_pkg.sv
// coax_pkg: constants and types shared by the coax receive-side blocks.
package coax_pkg;

    localparam int COAX_WORD_WIDTH      = 10;
    localparam int COAX_FRAME_LEN_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RECEIVE,
        DRAIN,
        DONE
    } coax_rx_ctrl_state_t;

endpackage

// File: rtl/coax_sync_fifo.sv
// coax_sync_fifo: single-clock FIFO with extra-MSB pointers for full/empty.
// A write while full is still accepted when a read frees a slot in the same cycle.
module coax_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    // The head is forced to zero while empty so the output is defined after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards all contents.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop updates from pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the array is not reset; validity is tracked by the pointers alone.
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/coax_rx_ctrl.sv
// coax_rx_ctrl: sequences coax_rx for one response frame, buffering words
// into a FIFO and reporting length/overflow at frame end.
// Optional feature macro: COAX_RX_CTRL_TIMEOUT_EN (WAIT timeout counter).
module coax_rx_ctrl
    import coax_pkg::*;
#(
    parameter int DEPTH          = 32,
    parameter int TIMEOUT_CLOCKS = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            arm,
    input  logic                            rx_active,
    input  logic [COAX_WORD_WIDTH-1:0]      rx_data,
    input  logic                            rx_data_available,
    output logic                            rx_data_read,
    output logic                            busy,
    input  logic                            rd_en,
    output logic [COAX_WORD_WIDTH-1:0]      rd_data,
    output logic                            empty,
    output logic                            frame_done,
    output logic [COAX_FRAME_LEN_WIDTH-1:0] frame_length,
    output logic                            overflow,
    output logic                            timeout
);

    coax_rx_ctrl_state_t state;
    coax_rx_ctrl_state_t state_next;

    logic                            rx_active_q;
    logic                            rx_rise;
    logic                            in_frame;
    logic                            capture;
    logic                            drop;
    logic                            fifo_full;
    logic                            arm_accept;
    logic                            tmo_expired;
    logic [COAX_FRAME_LEN_WIDTH-1:0] word_cnt;
    logic [COAX_FRAME_LEN_WIDTH-1:0] word_cnt_inc;

    // The receiver is always drained so it never holds a stale word.
    assign rx_data_read = rx_data_available;
    assign rx_rise      = rx_active && !rx_active_q;
    assign in_frame     = (state == WAIT) || (state == RECEIVE) || (state == DRAIN);
    assign capture      = in_frame && rx_data_available;
    // Full implies non-empty, so any rd_en frees a slot for this word.
    assign drop         = capture && fifo_full && !rd_en;
    assign word_cnt_inc = (capture && (word_cnt != '1))
                        ? word_cnt + COAX_FRAME_LEN_WIDTH'(1) : word_cnt;

`ifdef COAX_RX_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLOCKS) + 1;

    logic [TMO_W-1:0] tmo_cnt;

    // Counts clocks spent in WAIT; restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT) tmo_cnt <= '0;
        else                        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    assign tmo_expired = (state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CLOCKS - 1));
`else
    assign tmo_expired = 1'b0;
`endif

    // Next-state decode; a rising rx_active takes priority over timeout.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch forms.
        state_next = state;
        timeout    = 1'b0;
        arm_accept = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    arm_accept = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (rx_rise) begin
                    state_next = RECEIVE;
                end else if (tmo_expired) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            RECEIVE: if (!rx_active) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, registered status outputs and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            rx_active_q  <= 1'b0;
            word_cnt     <= '0;
            frame_length <= '0;
            overflow     <= 1'b0;
        end else begin
            state       <= state_next;
            busy        <= (state_next == WAIT) || (state_next == RECEIVE)
                        || (state_next == DRAIN);
            frame_done  <= (state_next == DONE);
            rx_active_q <= rx_active;

            if (state == IDLE) word_cnt <= '0;
            else               word_cnt <= word_cnt_inc;

            // Results persist through IDLE and are cleared only by the next arm.
            if (arm_accept) begin
                frame_length <= '0;
                overflow     <= 1'b0;
            end else begin
                if (drop)           overflow     <= 1'b1;
                if (state == DRAIN) frame_length <= word_cnt_inc;
            end
        end
    end

    coax_sync_fifo #(
        .WIDTH (COAX_WORD_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_coax_rx_ctrl.sv
// tb_coax_rx_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based frame model. Honors COAX_RX_CTRL_TIMEOUT_EN.
module tb_coax_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int TC    = 64;
    localparam int W     = 10;
`ifdef COAX_RX_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         arm = 1'b0;
    logic         rx_active = 1'b0;
    logic         rx_data_available = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] rx_data = '0;
    logic [W-1:0] rd_data;
    logic         rx_data_read;
    logic         busy;
    logic         empty;
    logic         frame_done;
    logic         overflow;
    logic         timeout;
    logic [7:0]   frame_length;

    int n_cmp = 0;
    int n_fail = 0;
    int n_done_seen = 0;
    int n_tmo_seen = 0;

    always #5 clk = ~clk;

    coax_rx_ctrl #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CLOCKS (TC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .arm               (arm),
        .rx_active         (rx_active),
        .rx_data           (rx_data),
        .rx_data_available (rx_data_available),
        .rx_data_read      (rx_data_read),
        .busy              (busy),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .empty             (empty),
        .frame_done        (frame_done),
        .frame_length      (frame_length),
        .overflow          (overflow),
        .timeout           (timeout)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_WAIT = 1, P_RECV = 2, P_DRAIN = 3, P_DONE = 4;

    int           m_phase = P_IDLE;
    logic [W-1:0] m_q[$];
    int           m_len = 0;
    int           m_frame_len = 0;
    int           m_wait = 0;
    bit           m_ovf = 1'b0;
    bit           m_prev_active = 1'b0;
    bit           m_valid = 1'b0;

    function automatic bit m_listening();
        return (m_phase == P_WAIT) || (m_phase == P_RECV) || (m_phase == P_DRAIN);
    endfunction

    function automatic bit exp_timeout();
        return TMO_EN && (m_phase == P_WAIT) && (m_wait == TC - 1)
            && !(rx_active && !m_prev_active);
    endfunction

    task automatic model_step();
        bit cap;
        bit pop;
        bit full;
        if (reset) begin
            m_phase = P_IDLE; m_q.delete(); m_len = 0; m_frame_len = 0;
            m_wait = 0; m_ovf = 1'b0; m_prev_active = 1'b0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        cap  = m_listening() && rx_data_available;
        full = (m_q.size() == DEPTH);
        pop  = rd_en && (m_q.size() != 0);
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            m_len++;
            if (full && !pop) m_ovf = 1'b1;
            else              m_q.push_back(rx_data);
        end
        case (m_phase)
            P_IDLE: if (arm) begin
                m_phase = P_WAIT; m_len = 0; m_ovf = 1'b0; m_frame_len = 0; m_wait = 0;
            end
            P_WAIT: begin
                if (rx_active && !m_prev_active)    m_phase = P_RECV;
                else if (TMO_EN && m_wait == TC - 1) m_phase = P_IDLE;
                else                                 m_wait++;
            end
            P_RECV:  if (!rx_active) m_phase = P_DRAIN;
            P_DRAIN: begin
                m_phase = P_DONE;
                m_frame_len = (m_len > 255) ? 255 : m_len;
            end
            default: m_phase = P_IDLE;
        endcase
        m_prev_active = rx_active;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("rx_data_read", rx_data_read, rx_data_available);
            check("busy", busy, m_listening());
            check("empty", empty, m_q.size() == 0);
            if (m_q.size() != 0) check("rd_data", rd_data, m_q[0]);
            check("frame_done", frame_done, m_phase == P_DONE);
            check("frame_length", frame_length, m_frame_len);
            check("overflow", overflow, m_ovf);
            check("timeout", timeout, exp_timeout());
        end
        if (frame_done === 1'b1) n_done_seen++;
        if (timeout === 1'b1)    n_tmo_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; arm = 1'b0; rx_active = 1'b0;
        rx_data_available = 1'b0; rd_en = 1'b0; rx_data = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        rx_data = w; rx_data_available = 1'b1;
        step();
        rx_data_available = 1'b0;
    endtask

    task automatic start_frame();
        arm = 1'b1; step(); arm = 1'b0;
        rx_active = 1'b1; step();
    endtask

    logic [W-1:0] t1_words[3] = '{10'h155, 10'h2AA, 10'h001};
    logic [W-1:0] t3_words[6] = '{10'h101, 10'h202, 10'h303, 10'h304, 10'h305, 10'h306};
    int done0;
    int tmo0;
    int tmo_at;

    initial begin
        do_reset();
        check("reset_busy", busy, 0);
        check("reset_empty", empty, 1);
        check("reset_rd_data", rd_data, 0);
        check("reset_frame_length", frame_length, 0);

        // Basic three-word frame with widely spaced words.
        arm = 1'b1; step(); arm = 1'b0;
        check("t1_busy_after_arm", busy, 1);
        repeat (19) step();
        rx_active = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            repeat (79) step();
            send_word(t1_words[i]);
        end
        step();
        rx_active = 1'b0; step();
        check("t1_drain_no_done", frame_done, 0);
        step();
        check("t1_frame_done", frame_done, 1);
        check("t1_frame_length", frame_length, 3);
        check("t1_overflow", overflow, 0);
        step();
        check("t1_idle_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("t1_pop", rd_data, t1_words[i]);
            rd_en = 1'b1; step(); rd_en = 1'b0;
        end
        check("t1_empty", empty, 1);

        // Arm with no activity.
        done0 = n_done_seen;
        tmo0  = n_tmo_seen;
        arm = 1'b1; step(); arm = 1'b0;
`ifdef COAX_RX_CTRL_TIMEOUT_EN
        tmo_at = -1;
        for (int k = 1; k <= 200; k++) begin
            if (timeout) begin
                tmo_at = k;
                break;
            end
            step();
        end
        check("t2_timeout_clock", tmo_at, 64);
        step();
        check("t2_busy_after_timeout", busy, 0);
        check("t2_no_frame_done", n_done_seen, done0);
`else
        repeat (200) step();
        check("t2_still_waiting", busy, 1);
        check("t2_no_timeout", n_tmo_seen, tmo0);
`endif

        // Overflow: six words into a four-deep FIFO with no reads.
        do_reset();
        start_frame();
        for (int i = 0; i < 6; i++) send_word(t3_words[i]);
        rx_active = 1'b0; step(); step();
        check("t3_frame_done", frame_done, 1);
        check("t3_frame_length", frame_length, 6);
        check("t3_overflow", overflow, 1);
        step();

        // Full FIFO, read and write in the same cycle.
        start_frame();
        check("t4_head", rd_data, t3_words[0]);
        rd_en = 1'b1;
        send_word(10'h3C3);
        rd_en = 1'b0;
        rx_active = 1'b0; step(); step();
        check("t4_frame_length", frame_length, 1);
        check("t4_overflow", overflow, 0);
        step();
        for (int i = 1; i < 4; i++) begin
            check("t3_pop", rd_data, t3_words[i]);
            rd_en = 1'b1; step(); rd_en = 1'b0;
        end
        check("t4_pop", rd_data, 10'h3C3);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        check("t4_empty", empty, 1);

        // Word in IDLE is discarded; arm during RECEIVE is ignored.
        do_reset();
        rx_data = 10'h0F0; rx_data_available = 1'b1;
        #1;
        check("t5_read_in_idle", rx_data_read, 1);
        step();
        rx_data_available = 1'b0;
        check("t5_idle_empty", empty, 1);
        done0 = n_done_seen;
        start_frame();
        send_word(10'h111);
        arm = 1'b1; step(); arm = 1'b0;
        check("t5_busy_in_receive", busy, 1);
        rx_active = 1'b0; step(); step();
        check("t5_frame_length", frame_length, 1);
        repeat (5) step();
        check("t5_single_frame_done", n_done_seen - done0, 1);
        check("t5_idle_after", busy, 0);

        // Reset in the middle of RECEIVE.
        start_frame();
        send_word(10'h222);
        send_word(10'h333);
        done0 = n_done_seen;
        reset = 1'b1; step(); reset = 1'b0;
        rx_active = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_empty", empty, 1);
        check("t6_frame_length", frame_length, 0);
        check("t6_frame_done", frame_done, 0);
        check("t6_rd_data", rd_data, 0);
        repeat (10) step();
        check("t6_no_frame_done", n_done_seen, done0);

        // Frame length saturation with continuous host reads.
        start_frame();
        rd_en = 1'b1;
        for (int i = 0; i < 260; i++) send_word(W'($urandom_range(0, 1023)));
        rx_active = 1'b0; step(); step();
        rd_en = 1'b0;
        check("t7_frame_length_sat", frame_length, 255);
        check("t7_overflow", overflow, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            rd_en = 1'b1; step();
        end
        rd_en = 1'b0;
        check("t7_empty", empty, 1);

        // Randomized traffic: fast then slow rx_active toggling.
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 3000; c++) begin
                reset             = ($urandom_range(0, 399) == 0);
                arm               = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, (phase == 0) ? 11 : 149) == 0) rx_active = !rx_active;
                rx_data_available = ($urandom_range(0, 2) == 0);
                rx_data           = W'($urandom_range(0, 1023));
                rd_en             = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        reset = 1'b0; arm = 1'b0; rx_data_available = 1'b0; rd_en = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
